// File: rtl/mul4_eval_pkg.sv
// rtl/mul4_eval_pkg.sv - shared constants, state type and reference planes for the 2x2 multiplier evaluator
package mul4_eval_pkg;

   localparam int LANES  = 16;
   localparam int PLANES = 4;

   typedef enum logic [2:0] {IDLE, LOAD, WAIT, SCORE, FIN} state_t;

   // Plane j bit i holds bit j of lane index (i+k) mod 16, packed as {a1,a0,b1,b0}.
   function automatic logic [PLANES*LANES-1:0] operand_planes(input logic [3:0] k);
      logic [3:0] idx;
      operand_planes = '0;
      for (int i = 0; i < LANES; i++) begin
         idx = 4'(i) + k;
         for (int j = 0; j < PLANES; j++) operand_planes[j*LANES + i] = idx[j];
      end
   endfunction

   // Expected product planes packed as {g3,g2,g1,g0} for round k.
   function automatic logic [PLANES*LANES-1:0] golden_planes(input logic [3:0] k);
      logic [3:0] idx;
      logic [3:0] prod;
      golden_planes = '0;
      for (int i = 0; i < LANES; i++) begin
         idx  = 4'(i) + k;
         prod = {2'b00, idx[3:2]} * {2'b00, idx[1:0]};
         for (int p = 0; p < PLANES; p++) golden_planes[p*LANES + i] = prod[p];
      end
   endfunction

endpackage

// File: rtl/mul4_fitness_eval_popcount16.sv
// rtl/mul4_fitness_eval_popcount16.sv - combinational 16-bit population count
module popcount16 (
   input  logic [15:0] data,
   output logic [4:0]  count
);

   always_comb begin
      count = '0;
      for (int i = 0; i < 16; i++) count = count + 5'(data[i]);
   end

endmodule

// File: rtl/mul4_fitness_eval.sv
// rtl/mul4_fitness_eval.sv - scores a bit-sliced 2x2 multiplier candidate over ROUNDS rotated lane sets
module mul4_fitness_eval
   import mul4_eval_pkg::*;
#(
   parameter int ROUNDS   = 4,
   parameter int CAND_LAT = 0,
   parameter int SW       = $clog2(64*ROUNDS+1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic [15:0]   a1,
   output logic [15:0]   a0,
   output logic [15:0]   b1,
   output logic [15:0]   b0,
   input  logic [15:0]   y3,
   input  logic [15:0]   y2,
   input  logic [15:0]   y1,
   input  logic [15:0]   y0,
   output logic [SW-1:0] score,
   output logic          perfect
);

   localparam int MAX_SCORE = LANES*PLANES*ROUNDS;

   state_t                    state;
   logic [3:0]                k;
   logic [2:0]                wcnt;
   logic [1:0]                p;
   logic [PLANES*LANES-1:0]   ycap;
   logic [PLANES*LANES-1:0]   gold;
   logic [PLANES*LANES-1:0]   ops;
   logic [LANES-1:0]          match;
   logic [4:0]                pc;

   assign gold  = golden_planes(k);
   assign ops   = operand_planes(k);
   assign match = ~(ycap[p*LANES +: LANES] ^ gold[p*LANES +: LANES]);

   // One counter serves all four planes; p walks the planes during SCORE.
   popcount16 u_popcount (
      .data  (match),
      .count (pc)
   );

   assign busy    = (state != IDLE);
   assign perfect = (score == SW'(MAX_SCORE));

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         k                <= '0;
         wcnt             <= '0;
         p                <= '0;
         score            <= '0;
         done             <= 1'b0;
         ycap             <= '0;
         {a1, a0, b1, b0} <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  score <= '0;
                  k     <= '0;
                  state <= LOAD;
               end
            end
            LOAD: begin
               {a1, a0, b1, b0} <= ops;
               wcnt             <= '0;
               state            <= WAIT;
            end
            WAIT: begin
               if (wcnt == 3'(CAND_LAT)) begin
                  ycap  <= {y3, y2, y1, y0};
                  p     <= '0;
                  state <= SCORE;
               end else begin
                  wcnt <= wcnt + 3'd1;
               end
            end
            SCORE: begin
               score <= score + SW'(pc);
               if (p == 2'd3) begin
                  if (k == 4'(ROUNDS-1)) begin
                     done  <= 1'b1;
                     state <= FIN;
                  end else begin
                     k     <= k + 4'd1;
                     state <= LOAD;
                  end
               end else begin
                  p <= p + 2'd1;
               end
            end
            FIN: begin
               {a1, a0, b1, b0} <= '0;
               state            <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/mul4_fitness_eval.md
MUL4_FITNESS_EVAL -- requirements
Module: mul4_fitness_eval

Interface
REQ-001 The module SHALL have parameter ROUNDS, default 4, giving the number of evaluation rounds, legal range 1..16.
REQ-002 The module SHALL have parameter CAND_LAT, default 0, giving the candidate pipeline latency in cycles, legal range 0..7.
REQ-003 The module SHALL have parameter SW, default $clog2(64*ROUNDS+1), giving the score width.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 start  input  1  request to begin an evaluation; SHALL be sampled only in IDLE.
REQ-007 busy  output  1  SHALL be high in every state except IDLE.
REQ-008 done  output  1  single-cycle pulse when the score is final.
REQ-009 a1, a0, b1, b0  output  16 each  bit-sliced operand planes driven to the candidate; lane i is bit i.
REQ-010 y3, y2, y1, y0  input  16 each  bit-sliced product planes returned by the candidate.
REQ-011 score  output  SW  count of correct product bits over all rounds.
REQ-012 perfect  output  1  SHALL be high when score equals 64*ROUNDS.

Function
REQ-013 The FSM SHALL have states IDLE, LOAD, WAIT, SCORE and FIN.
REQ-014 FSM transitions SHALL be:
- IDLE->LOAD on start (score cleared, round counter k=0).
- LOAD->WAIT after 1 cycle.
- WAIT->SCORE after CAND_LAT+1 cycles.
- SCORE->LOAD (k+1) after 4 cycles, or SCORE->FIN when k=ROUNDS-1.
- FIN->IDLE after 1 cycle, with done high in FIN.
REQ-015 In LOAD, the lane index of round k SHALL be idx(i)=(i+k) mod 16, and the module SHALL register a1[i]=idx[3], a0[i]=idx[2], b1[i]=idx[1], b0[i]=idx[0].
REQ-016 The operand planes SHALL hold stable from LOAD until the next LOAD; they SHALL be zero in IDLE.
REQ-017 On the last WAIT cycle, the module SHALL capture y3..y0 into a 64-bit register.
REQ-018 The golden planes g3..g0 SHALL have lane i equal to the 4-bit value (2*idx[3]+idx[2])*(2*idx[1]+idx[0]).
REQ-019 SCORE cycle p (p=0..3) SHALL add popcount16(~(yp_cap ^ gp)) to score, one plane per cycle.
REQ-020 The module SHALL evaluate exactly 64 bits per round, so score never exceeds 64*ROUNDS, and the accumulator SHALL NOT wrap.
REQ-021 done SHALL pulse exactly ROUNDS*(CAND_LAT+6)+1 edges after the start edge (25 for the defaults).
REQ-022 score and perfect SHALL hold their final values from FIN until the next accepted start.
REQ-023 start while busy SHALL be ignored, with no restart and no effect on score.
REQ-024 start held high SHALL re-trigger only after the FSM returns to IDLE, with score cleared on acceptance.
REQ-025 X or Z on y inputs outside the capture cycle SHALL have no effect.

Reset
REQ-026 rst SHALL force IDLE, k=0, score=0, perfect=0, done=0, busy=0, all operand planes=0 and the capture register=0.
REQ-027 rst asserted in any state, including mid-SCORE, SHALL abort the evaluation with no done pulse, and rst SHALL take priority over start in the same cycle.

Structure
REQ-028 Package mul4_eval_pkg SHALL hold the lane count (16), the plane count (4), the state enum type and the golden-product function.
REQ-029 Sub-module popcount16 (16-bit in, 5-bit combinational count) SHALL be instantiated once and time-shared across the 4 planes.

Verification
REQ-030 An ideal combinational multiplier with defaults and start pulsed SHALL give done at edge +25, score=256 and perfect=1.
REQ-031 A candidate with all y planes 0x0000 SHALL give score=200 (50 zero product bits per round) and perfect=0.
REQ-032 A candidate with all y planes 0xFFFF SHALL give score=56 (14 one bits per round).
REQ-033 With CAND_LAT=2 and an ideal multiplier delayed by 2 registers, the result SHALL be score=256 and done at edge +33; the undelayed multiplier with CAND_LAT=2 SHALL also score 256.
REQ-034 rst asserted during round 2 SCORE SHALL give no done pulse, all outputs 0 on the next edge, and a following start SHALL evaluate cleanly to 256.
REQ-035 A second start pulse mid-evaluation SHALL be ignored, with a single done pulse and unchanged timing.
